rf_writeback: RTL and testbench

RF_WRITEBACK -- requirements
Module: rf_writeback

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_fifo.sv | 63 ++++++
 rtl/rf_writeback.sv | 112 +++++++++++
 tb/tb_rf_writeback.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file writeback block.
package wb_pkg;

  localparam int         WB_DEPTH  = 4;
  localparam logic [3:0] WB_PC_REG = 4'd15;

  // One queued register write.
  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } wb_entry_t;

  // Identity of the source that won the most recent grant.
  typedef enum logic {
    SRC_LD  = 1'b0,
    SRC_ALU = 1'b1
  } wb_src_e;

  // Register index to a 16-bit one-hot flag vector.
  function automatic logic [15:0] reg_onehot(input logic [3:0] a);
    reg_onehot = 16'h0001 << a;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order write queue. It exposes its storage and head pointer so that the
// parent can derive which registers still have writes in flight.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_push,
  input  wb_entry_t                   i_entry,
  input  logic                        i_pop,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [$clog2(DEPTH):0]      o_count,
  output logic [$clog2(DEPTH)-1:0]    o_head_ptr,
  output wb_entry_t [DEPTH-1:0]       o_entries
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t [DEPTH-1:0] r_mem;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [PW:0]           r_count;
  logic                  w_push;
  logic                  w_pop;

  assign o_full     = (r_count == (PW+1)'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign w_push     = i_push && !o_full;
  assign w_pop      = i_pop && !o_empty;
  assign o_count    = r_count;
  assign o_head_ptr = r_head;
  assign o_entries  = r_mem;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Entry storage, written at the tail on every accepted push.
  // NOTE: storage carries no reset; an entry only becomes visible once the
  // count covers it, so its power-up contents are never observed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= i_entry;
  end

endmodule

// File: rtl/rf_writeback.sv
// Register-file writeback: arbitrates ALU and load results into an in-order
// write queue, drains it through the general write port, and lets a PC update
// take the cycle (stalling the queue head) whenever one is requested.
module rf_writeback
  import wb_pkg::*;
#(
  parameter int         DEPTH  = WB_DEPTH,
  parameter logic [3:0] PC_REG = WB_PC_REG
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [3:0]  alu_addr,
  input  logic [15:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [3:0]  ld_addr,
  input  logic [15:0] ld_data,
  input  logic        pc_valid,
  input  logic [15:0] pc_new,
  output logic        w_en,
  output logic [3:0]  w_addr,
  output logic [15:0] w_data,
  output logic        pc_en,
  output logic [3:0]  pc_addr,
  output logic [15:0] pc_data,
  output logic [15:0] pending
);

  localparam int PW = $clog2(DEPTH);

  wb_src_e               r_last_grant;
  logic                  w_grant_ld;
  logic                  w_grant_alu;
  logic                  w_ld_xfer;
  logic                  w_alu_xfer;
  logic                  w_push;
  wb_entry_t             w_push_entry;
  wb_entry_t             w_head;
  logic                  w_full;
  logic                  w_empty;
  logic [PW:0]           w_count;
  logic [PW-1:0]         w_head_ptr;
  wb_entry_t [DEPTH-1:0] w_entries;

  // Round-robin grant: a lone requester wins outright, a tie goes to the
  // source that did not win last time.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    w_grant_ld  = 1'b0;
    w_grant_alu = 1'b0;
    if (ld_valid && alu_valid) begin
      if (r_last_grant == SRC_ALU) w_grant_ld  = 1'b1;
      else                         w_grant_alu = 1'b1;
    end else begin
      w_grant_ld  = ld_valid;
      w_grant_alu = alu_valid;
    end
  end

  // Ready looks only at occupancy, never at a same-cycle pop.
  assign ld_ready     = !rst && w_grant_ld  && !w_full;
  assign alu_ready    = !rst && w_grant_alu && !w_full;
  assign w_ld_xfer    = ld_valid  && ld_ready;
  assign w_alu_xfer   = alu_valid && alu_ready;
  assign w_push       = w_ld_xfer || w_alu_xfer;
  assign w_push_entry = w_ld_xfer ? wb_entry_t'{addr: ld_addr,  data: ld_data}
                                  : wb_entry_t'{addr: alu_addr, data: alu_data};

  // Remember the winner of the last actual transfer; reset favours load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_last_grant <= SRC_ALU;
    else if (w_ld_xfer)  r_last_grant <= SRC_LD;
    else if (w_alu_xfer) r_last_grant <= SRC_ALU;
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_entry    (w_push_entry),
    .i_pop      (w_en),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count),
    .o_head_ptr (w_head_ptr),
    .o_entries  (w_entries)
  );

  // PC port is a straight combinational pass-through and owns the cycle.
  assign pc_en   = pc_valid;
  assign pc_addr = PC_REG;
  assign pc_data = pc_new;

  // General port drains the head unless a PC update is stealing the cycle.
  assign w_head = w_entries[w_head_ptr];
  assign w_en   = !w_empty && !pc_valid;
  assign w_addr = w_en ? w_head.addr : 4'd0;
  assign w_data = w_en ? w_head.data : 16'd0;

  // Pending flags: OR of one-hot destinations over the occupied slots.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, PW'(i) - w_head_ptr} < w_count)
        pending = pending | reg_onehot(w_entries[i].addr);
    end
  end

endmodule

// File: tb/tb_rf_writeback.sv
// Self-checking bench for rf_writeback: a queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_rf_writeback;

  localparam int         DEPTH  = 4;
  localparam logic [3:0] PC_REG = 4'd15;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, ld_valid, pc_valid;
  logic        alu_ready, ld_ready;
  logic [3:0]  alu_addr, ld_addr;
  logic [15:0] alu_data, ld_data, pc_new;
  logic        w_en, pc_en;
  logic [3:0]  w_addr, pc_addr;
  logic [15:0] w_data, pc_data, pending;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  rf_writeback #(.DEPTH(DEPTH), .PC_REG(PC_REG)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .pc_valid  (pc_valid),
    .pc_new    (pc_new),
    .w_en      (w_en),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .pc_en     (pc_en),
    .pc_addr   (pc_addr),
    .pc_data   (pc_data),
    .pending   (pending)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [19:0] mq[$];        // {addr, data}, oldest first
  bit          m_last_alu = 1'b1;

  function automatic void model_ready(output bit lr, output bit ar);
    bit gl, ga;
    if (ld_valid && alu_valid) begin
      gl = m_last_alu;
      ga = !m_last_alu;
    end else begin
      gl = ld_valid;
      ga = alu_valid;
    end
    lr = gl && (mq.size() < DEPTH) && !rst;
    ar = ga && (mq.size() < DEPTH) && !rst;
  endfunction

  always @(posedge clk or posedge rst) begin : model_update
    bit lr, ar;
    if (rst) begin
      mq.delete();
      m_last_alu = 1'b1;
    end else begin
      model_ready(lr, ar);
      if (mq.size() > 0 && !pc_valid) void'(mq.pop_front());
      if (ld_valid && lr) begin
        mq.push_back({ld_addr, ld_data});
        m_last_alu = 1'b0;
      end else if (alu_valid && ar) begin
        mq.push_back({alu_addr, alu_data});
        m_last_alu = 1'b1;
      end
    end
  end

  always @(negedge clk) begin : compare
    bit          lr, ar, ew;
    logic [15:0] ep;
    logic [19:0] hd;
    model_ready(lr, ar);
    ew = (mq.size() > 0) && !pc_valid;
    hd = ew ? mq[0] : 20'd0;
    ep = '0;
    foreach (mq[k]) ep = ep | (16'h0001 << mq[k][19:16]);
    check("cyc ld_ready",  ld_ready,  lr);
    check("cyc alu_ready", alu_ready, ar);
    check("cyc w_en",      w_en,      ew);
    check("cyc w_addr",    w_addr,    hd[19:16]);
    check("cyc w_data",    w_data,    hd[15:0]);
    check("cyc pending",   pending,   ep);
    check("cyc pc_en",     pc_en,     pc_valid);
    check("cyc pc_addr",   pc_addr,   PC_REG);
    check("cyc pc_data",   pc_data,   pc_new);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; ld_valid = 0; pc_valid = 0;
    alu_addr = 0; alu_data = 0; ld_addr = 0; ld_data = 0; pc_new = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1;
    // Reset state: readies held low even with requests, PC port still live.
    alu_valid = 1; ld_valid = 1; pc_valid = 1; pc_new = 16'h1234;
    #1;
    check("rst alu_ready", alu_ready, 0);
    check("rst ld_ready",  ld_ready,  0);
    check("rst w_en",      w_en,      0);
    check("rst pending",   pending,   0);
    check("rst pc_en",     pc_en,     1);
    check("rst pc_addr",   pc_addr,   15);
    check("rst pc_data",   pc_data,   16'h1234);
    idle_inputs();
    tick();
    do_reset();

    // Single ALU write: visible next cycle, retired one edge later.
    alu_valid = 1; alu_addr = 3; alu_data = 16'h1234;
    #1 check("a alu_ready", alu_ready, 1);
    tick();
    alu_valid = 0;
    #1;
    check("a w_en",    w_en,    1);
    check("a w_addr",  w_addr,  3);
    check("a w_data",  w_data,  16'h1234);
    check("a pending", pending, 16'h0008);
    tick();
    check("a w_en off",    w_en,    0);
    check("a pending off", pending, 0);
    check("a w_addr zero", w_addr,  0);
    check("a w_data zero", w_data,  0);

    // Both sources valid: ld, alu, ld, alu; drain shows same order.
    do_reset();
    pc_valid = 1;
    ld_valid = 1;  ld_addr = 1;  ld_data = 16'h1111;
    alu_valid = 1; alu_addr = 2; alu_data = 16'h2222;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr ld_ready",  ld_ready,  (k % 2 == 0));
      check("rr alu_ready", alu_ready, (k % 2 == 1));
      tick();
    end
    #1;
    check("rr full ld_ready",  ld_ready,  0);
    check("rr full alu_ready", alu_ready, 0);
    check("rr pending",        pending,   16'h0006);
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr order w_en",   w_en,   1);
      check("rr order w_addr", w_addr, (k % 2 == 0) ? 4'd1 : 4'd2);
      check("rr order w_data", w_data, (k % 2 == 0) ? 16'h1111 : 16'h2222);
      tick();
    end
    check("rr drained", w_en, 0);

    // Five pushes under a held PC update: four accepted, fifth waits.
    do_reset();
    pc_valid = 1; pc_new = 16'h0040;
    alu_valid = 1; alu_addr = 4; alu_data = 16'h4444;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("full alu_ready", alu_ready, (k < 4));
      check("full w_en",      w_en,      0);
      tick();
    end
    check("full pending", pending, 16'h0010);
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      #1 check("full drain w_en", w_en, 1);
      tick();
    end
    check("full drain end", w_en, 0);

    // Stall on PC update, then release.
    do_reset();
    ld_valid = 1; ld_addr = 5; ld_data = 16'hAAAA;
    pc_valid = 1; pc_new = 16'h0040;
    tick();
    ld_valid = 0;
    #1;
    check("stall pc_en",   pc_en,   1);
    check("stall pc_addr", pc_addr, 15);
    check("stall pc_data", pc_data, 16'h0040);
    check("stall w_en",    w_en,    0);
    check("stall pending", pending, 16'h0020);
    tick();
    check("stall held w_en", w_en, 0);
    pc_valid = 0;
    #1;
    check("release w_en",   w_en,   1);
    check("release w_addr", w_addr, 5);
    check("release w_data", w_data, 16'hAAAA);
    tick();
    check("release done", w_en, 0);

    // Two writes to r7: pending stays until the second retires.
    do_reset();
    alu_valid = 1; alu_addr = 7; alu_data = 16'h0701;
    tick();
    check("r7 first w_data", w_data,  16'h0701);
    check("r7 first pending", pending, 16'h0080);
    alu_data = 16'h0702;
    tick();
    alu_valid = 0;
    #1;
    check("r7 second w_data",  w_data,  16'h0702);
    check("r7 second pending", pending, 16'h0080);
    tick();
    check("r7 cleared", pending, 0);

    // A load targeting the PC register goes through the general port.
    ld_valid = 1; ld_addr = 15; ld_data = 16'hBEEF;
    tick();
    ld_valid = 0;
    #1;
    check("pcreg w_en",   w_en,   1);
    check("pcreg w_addr", w_addr, 15);
    check("pcreg w_data", w_data, 16'hBEEF);
    check("pcreg pc_en",  pc_en,  0);
    tick();

    // Asynchronous reset with three entries queued.
    do_reset();
    pc_valid = 1;
    alu_valid = 1;
    for (int k = 0; k < 3; k++) begin
      alu_addr = 4'(8 + k);
      alu_data = 16'(16'hC000 + k);
      tick();
    end
    alu_valid = 0;
    #1 check("async pending before", pending, 16'h0700);
    pc_valid = 0;
    #1 check("async w_en before", w_en, 1);
    #1 rst = 1;
    #1;
    check("async w_en",    w_en,    0);
    check("async pending", pending, 0);
    tick();
    rst = 0;
    tick();
    check("async deassert w_en",    w_en,    0);
    check("async deassert pending", pending, 0);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
